// File: rtl/instr_fetch.sv
// Instruction fetch: issues single-outstanding memory reads from the next-PC stream
// and buffers {pc, instruction} pairs in a small FIFO for decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] fetch_pc
);

    // state  | meaning
    // IDLE   | no request outstanding
    // REQ    | request outstanding, returned word is kept
    // DROP   | request outstanding, returned word is discarded (stream redirected)
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]    state;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          pop;
    logic          push;
    logic          ack_hit;
    logic          space;
    logic [31:0]   pc_inc;
    logic [31:0]   redirect_aligned;

    assign instr_valid      = (count != '0);
    assign pop              = instr_valid & instr_ready;
    assign ack_hit          = mem_req & mem_ack;
    assign push             = (state == S_REQ) & ack_hit & ~redirect_valid;
    assign pc_inc           = fetch_pc + 32'd4;
    assign redirect_aligned = redirect_pc & ~32'h0000_0003;

    // Occupancy after this edge decides whether a new request may be issued,
    // so there is always a free slot waiting for the word in flight.
    always_comb begin
        count_next = count;
        if (redirect_valid) begin
            count_next = '0;
        end else begin
            count_next = count - CW'(pop) + CW'(push);
        end
    end

    assign space       = (count_next < DEPTH_C);
    assign instruction = instr_valid ? data_mem[head] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem[head]   : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            case (state)
                S_REQ, S_DROP: begin
                    // An issued request is never withdrawn; wait out its ack in DROP.
                    if (ack_hit) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                    end else begin
                        state <= S_DROP;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (space) begin
                        state    <= S_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                S_REQ: begin
                    if (ack_hit) begin
                        fetch_pc <= pc_inc;
                        if (space) begin
                            mem_addr <= pc_inc;
                        end else begin
                            state   <= S_IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (ack_hit) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect_valid) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count_next;
            if (pop) begin
                head <= head + AW'(1);
            end
            if (push) begin
                tail <= tail + AW'(1);
            end
        end
    end

    // Storage needs no reset: reads are gated by instr_valid.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[tail]   <= fetch_pc;
            data_mem[tail] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based fetch model compared every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] fetch_pc;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .fetch_pc       (fetch_pc)
    );

    always #5 clock = ~clock;

    // Reference model: what has been requested, where the stream is, and what
    // decode should be seeing, kept as plain values and queues.
    logic        m_req  = 1'b0;
    logic        m_drop = 1'b0;
    logic [31:0] m_addr = RESET_PC;
    logic [31:0] m_pc   = RESET_PC;
    logic [31:0] m_pcq[$];
    logic [31:0] m_dq[$];

    logic [31:0] req_log[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_data[$];

    logic auto_ack = 1'b0;
    int   ack_lat  = 0;
    int   wait_cnt = 0;

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_req  = 1'b0;
                m_drop = 1'b0;
                m_addr = RESET_PC;
                m_pc   = RESET_PC;
                m_pcq.delete();
                m_dq.delete();
            end else if (redirect_valid) begin
                m_pcq.delete();
                m_dq.delete();
                m_pc = redirect_pc & ~32'h3;
                if (m_req && mem_ack) begin
                    m_req  = 1'b0;
                    m_drop = 1'b0;
                end else if (m_req) begin
                    m_drop = 1'b1;
                end
            end else begin
                if (m_dq.size() > 0 && instr_ready) begin
                    void'(m_pcq.pop_front());
                    void'(m_dq.pop_front());
                end
                if (m_req && mem_ack) begin
                    if (m_drop) begin
                        m_req  = 1'b0;
                        m_drop = 1'b0;
                    end else begin
                        m_pcq.push_back(m_pc);
                        m_dq.push_back(mem_rdata);
                        m_pc = m_pc + 32'd4;
                        if (m_dq.size() < DEPTH) m_addr = m_pc;
                        else m_req = 1'b0;
                    end
                end else if (!m_req && m_dq.size() < DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = m_pc;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus a log of words decode accepted.
    always @(negedge clock) begin
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_data;
        e_valid = (m_dq.size() > 0);
        e_pc    = e_valid ? m_pcq[0] : 32'h0;
        e_data  = e_valid ? m_dq[0]  : 32'h0;
        n_tests++;
        if (mem_req !== m_req || mem_addr !== m_addr || fetch_pc !== m_pc ||
            instr_valid !== e_valid || instr_pc !== e_pc || instruction !== e_data) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t got req=%b addr=%h fpc=%h v=%b ipc=%h ins=%h want req=%b addr=%h fpc=%h v=%b ipc=%h ins=%h",
                     $time, mem_req, mem_addr, fetch_pc, instr_valid, instr_pc, instruction,
                     m_req, m_addr, m_pc, e_valid, e_pc, e_data);
        end
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            dlv_pc.push_back(instr_pc);
            dlv_data.push_back(instruction);
        end
    end

    // Auto memory responder: acks ack_lat cycles after a request appears, data = ~addr.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (auto_ack) begin
                mem_ack = 1'b0;
                if (mem_req && !reset) begin
                    if (wait_cnt == 0) req_log.push_back(mem_addr);
                    if (wait_cnt == ack_lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = ~mem_addr;
                        wait_cnt  = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic ack_now(input logic [31:0] data);
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack   = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic apply_reset();
        auto_ack       = 1'b0;
        mem_ack        = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        req_log.delete();
        dlv_pc.delete();
        dlv_data.delete();
    endtask

    function automatic logic seen_data(input logic [31:0] d);
        foreach (dlv_data[i]) if (dlv_data[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_ack        = 1'b0;
        mem_rdata      = 32'h0;
        instr_ready    = 1'b0;

        // Reset state
        apply_reset();
        check32("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_fetch_pc", fetch_pc, 32'h0);
        check32("rst_valid", {31'h0, instr_valid}, 32'h0);
        check32("rst_instruction", instruction, 32'h0);
        check32("rst_instr_pc", instr_pc, 32'h0);

        // Sequential fetch, ack two cycles after each request
        ack_lat     = 2;
        auto_ack    = 1'b1;
        instr_ready = 1'b1;
        reset       = 1'b0;
        tick();
        check32("seq_first_req", {31'h0, mem_req}, 32'h1);
        for (int i = 0; i < 60 && dlv_pc.size() < 3; i++) tick();
        if (dlv_pc.size() < 3) begin
            check32("seq_timeout_delivered", dlv_pc.size(), 3);
        end else begin
            check32("seq_req0", req_log[0], 32'h0);
            check32("seq_req1", req_log[1], 32'h4);
            check32("seq_req2", req_log[2], 32'h8);
            check32("seq_pc0", dlv_pc[0], 32'h0);
            check32("seq_pc1", dlv_pc[1], 32'h4);
            check32("seq_pc2", dlv_pc[2], 32'h8);
            check32("seq_ins1", dlv_data[1], 32'hFFFF_FFFB);
        end

        // Backpressure with zero-wait-state acks
        apply_reset();
        ack_lat  = 0;
        auto_ack = 1'b1;
        reset    = 1'b0;
        repeat (4) tick();
        check32("bp_req_low", {31'h0, mem_req}, 32'h0);
        check32("bp_fetch_pc", fetch_pc, 32'h8);
        check32("bp_valid", {31'h0, instr_valid}, 32'h1);
        check32("bp_head_pc", instr_pc, 32'h0);
        check32("bp_head_ins", instruction, 32'hFFFF_FFFF);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check32("bp_head_after_pop", instr_pc, 32'h4);
        check32("bp_rereq", {31'h0, mem_req}, 32'h1);
        check32("bp_rereq_addr", mem_addr, 32'h8);

        // Redirect with an outstanding request
        apply_reset();
        instr_ready = 1'b1;
        reset       = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) ack_now(32'h1000 + i);
        check32("rd_pending_addr", mem_addr, 32'h10);
        do_redirect(32'h100);
        check32("rd_flushed", {31'h0, instr_valid}, 32'h0);
        check32("rd_addr_held", mem_addr, 32'h10);
        check32("rd_req_held", {31'h0, mem_req}, 32'h1);
        check32("rd_fetch_pc", fetch_pc, 32'h100);
        tick();
        tick();
        ack_now(32'hDEAD_BEEF);
        check32("rd_drop_valid", {31'h0, instr_valid}, 32'h0);
        check32("rd_drop_req", {31'h0, mem_req}, 32'h0);
        tick();
        check32("rd_new_addr", mem_addr, 32'h100);
        ack_now(32'h0BAD_F00D);
        check32("rd_first_pc", instr_pc, 32'h100);
        check32("rd_first_ins", instruction, 32'h0BAD_F00D);

        // Redirect coincident with ack
        do_redirect(32'h20);
        ack_now(32'h5555_5555);
        tick();
        check32("co_addr_20", mem_addr, 32'h20);
        mem_ack        = 1'b1;
        mem_rdata      = 32'h0000_1234;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        mem_ack        = 1'b0;
        redirect_valid = 1'b0;
        check32("co_empty", {31'h0, instr_valid}, 32'h0);
        check32("co_req_low", {31'h0, mem_req}, 32'h0);
        tick();
        check32("co_addr_40", mem_addr, 32'h40);
        check32("co_1234_never", {31'h0, seen_data(32'h0000_1234)}, 32'h0);
        check32("rd_beef_never", {31'h0, seen_data(32'hDEAD_BEEF)}, 32'h0);

        // Misaligned redirect and address wrap
        do_redirect(32'h103);
        check32("mis_fetch_pc", fetch_pc, 32'h100);
        ack_now(32'h0);
        tick();
        check32("mis_addr", mem_addr, 32'h100);
        do_redirect(32'hFFFF_FFFC);
        ack_now(32'h0);
        tick();
        check32("wrap_top_addr", mem_addr, 32'hFFFF_FFFC);
        ack_now(32'hCAFE_0000);
        check32("wrap_next_addr", mem_addr, 32'h0);
        check32("wrap_fetch_pc", fetch_pc, 32'h0);
        check32("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);

        // Async reset while a request is outstanding
        check32("ar_pre_req", {31'h0, mem_req}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check32("ar_req_now", {31'h0, mem_req}, 32'h0);
        check32("ar_valid_now", {31'h0, instr_valid}, 32'h0);
        check32("ar_fetch_pc_now", fetch_pc, RESET_PC);
        tick();
        tick();
        dlv_pc.delete();
        dlv_data.delete();
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0BAD;
        tick();
        mem_ack = 1'b0;
        check32("ar_first_req", {31'h0, mem_req}, 32'h1);
        check32("ar_first_addr", mem_addr, RESET_PC);
        check32("ar_stale_valid", {31'h0, instr_valid}, 32'h0);
        ack_lat  = 1;
        auto_ack = 1'b1;
        for (int i = 0; i < 20 && dlv_pc.size() < 1; i++) tick();
        if (dlv_pc.size() < 1) begin
            check32("ar_timeout_delivered", dlv_pc.size(), 1);
        end else begin
            check32("ar_dlv_pc", dlv_pc[0], 32'h0);
            check32("ar_dlv_ins", dlv_data[0], 32'hFFFF_FFFF);
        end
        auto_ack = 1'b0;
        mem_ack  = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
